// File: rtl/hazard_sequencer.sv
// Load-use / branch / undefined-instruction sequencer for the 5-stage MIPS pipe.
// Optional HAZ_PERF_CNT_EN adds saturating stall_count / flush_count outputs.
module hazard_sequencer #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifid_inst,
    input  logic        undef_inst,
    input  logic        idex_memr,
    input  logic [4:0]  idex_rt,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        pipe_stall,
    output logic        halted,
    output logic [1:0]  state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    localparam int LSC = (LOAD_STALL_CYCLES < 1) ? 1 :
                         (LOAD_STALL_CYCLES > 3) ? 3 : LOAD_STALL_CYCLES;
    localparam int DC  = (DRAIN_CYCLES < 1) ? 1 :
                         (DRAIN_CYCLES > 7) ? 7 : DRAIN_CYCLES;
    localparam logic [2:0] LSC_LAST = 3'(LSC - 1);
    localparam logic [2:0] DC_LAST  = 3'(DC);

    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;

    state_t     cur_state, nxt_state;
    logic [2:0] cnt, cnt_nxt;
    logic [5:0] opcode;
    logic [4:0] rs, rt;
    logic       rt_src, load_use;
    logic       unused_inst_bits;

    assign opcode = ifid_inst[31:26];
    assign rs     = ifid_inst[25:21];
    assign rt     = ifid_inst[20:16];
    assign unused_inst_bits = ^ifid_inst[15:0];

    // rt is read only by R-type, beq, bne and sw
    assign rt_src   = (opcode == 6'b000000) || (opcode == 6'b000100) ||
                      (opcode == 6'b000101) || (opcode == 6'b101011);
    assign load_use = idex_memr && (idex_rt != 5'd0) &&
                      ((idex_rt == rs) || (rt_src && (idex_rt == rt)));

    assign state = cur_state;

    always_comb begin
        nxt_state  = cur_state;
        cnt_nxt    = cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pipe_stall = 1'b0;
        case (cur_state)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    pipe_stall = 1'b1;
                    cnt_nxt    = 3'd0;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_stall = 1'b1;
                    cnt_nxt    = 3'd1;
                    if (LSC != 1) nxt_state = STALL;
                end else if (undef_inst) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_stall = 1'b1;
                    cnt_nxt    = 3'd1;
                    nxt_state  = DRAIN;
                end else begin
                    cnt_nxt = 3'd0;
                end
            end
            STALL: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_stall = 1'b1;
                cnt_nxt    = cnt + 3'd1;
                if (cnt == LSC_LAST) begin
                    nxt_state = RUN;
                    cnt_nxt   = 3'd0;
                end
            end
            DRAIN: begin
                // An older branch still in EX wins: the undefined instruction is squashed
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    pipe_stall = 1'b1;
                    nxt_state  = RUN;
                    cnt_nxt    = 3'd0;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_stall = 1'b1;
                    cnt_nxt    = cnt + 3'd1;
                    if (cnt == DC_LAST) begin
                        nxt_state = HALT;
                        cnt_nxt   = 3'd0;
                    end
                end
            end
            default: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= RUN;
            cnt       <= 3'd0;
            halted    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
            if (nxt_state == HALT) halted <= 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (!pc_write && !halted && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
            if (ifid_flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: vector table, corner sequences and random stimulus
// checked against a bubble-counting reference model (two parameter sets).
module tb_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        undef, memr, br;
    logic [4:0]  irt;
    logic        a_pc, a_ifw, a_fl, a_ps, a_h;
    logic        b_pc, b_ifw, b_fl, b_ps, b_h;
    logic [1:0]  a_st, b_st;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] a_sc, a_fc, b_sc, b_fc;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_sequencer dut_a (
        .clk(clk), .rst(rst), .ifid_inst(inst), .undef_inst(undef), .idex_memr(memr),
        .idex_rt(irt), .branch_taken(br), .pc_write(a_pc), .ifid_write(a_ifw),
        .ifid_flush(a_fl), .pipe_stall(a_ps), .halted(a_h), .state(a_st)
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(a_sc), .flush_count(a_fc)
`endif
    );

    // Out-of-range parameters: must clamp to 3 stall and 7 drain cycles
    hazard_sequencer #(.LOAD_STALL_CYCLES(5), .DRAIN_CYCLES(9)) dut_b (
        .clk(clk), .rst(rst), .ifid_inst(inst), .undef_inst(undef), .idex_memr(memr),
        .idex_rt(irt), .branch_taken(br), .pc_write(b_pc), .ifid_write(b_ifw),
        .ifid_flush(b_fl), .pipe_stall(b_ps), .halted(b_h), .state(b_st)
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(b_sc), .flush_count(b_fc)
`endif
    );

    // Output bundle {pc_write, ifid_write, ifid_flush, pipe_stall, halted, state}
    localparam logic [6:0] O_RUN   = 7'b1100000;
    localparam logic [6:0] O_FRZ   = 7'b0001000;
    localparam logic [6:0] O_FLUSH = 7'b1111000;
    localparam logic [6:0] O_STALL = 7'b0001001;
    localparam logic [6:0] O_DRAIN = 7'b0001010;
    localparam logic [6:0] O_ABORT = 7'b1111010;
    localparam logic [6:0] O_HALT  = 7'b0001111;

    localparam logic [31:0] ADD_3_2_4 = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] ADDI_5_2  = {6'h08, 5'd2, 5'd5, 16'd1};
    localparam logic [31:0] SW_2_9    = {6'h2b, 5'd9, 5'd2, 16'd0};
    localparam logic [31:0] BEQ_7_2   = {6'h04, 5'd7, 5'd2, 16'd3};

    // Reference model: remaining stall / drain bubbles and a sticky halt flag
    int m_lsc [2] = '{1, 3};
    int m_dc  [2] = '{3, 7};
    int m_sl  [2];
    int m_dl  [2];
    bit m_h   [2];
    logic [6:0] la, lb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act[6:0], exp[6:0], $time);
        end
    endtask

    function automatic bit lu_ref(input logic [31:0] i, input logic m, input logic [4:0] r);
        int op;
        bit reads_rt;
        op = int'(i[31:26]);
        reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
        return m && r != 0 && (r == i[25:21] || (reads_rt && r == i[20:16]));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sl[d] = 0; m_dl[d] = 0; m_h[d] = 0;
        end
    endtask

    task automatic model_cycle(input int d, output logic [6:0] e);
        if (m_h[d]) e = O_HALT;
        else if (m_dl[d] > 0) begin
            if (br) begin e = O_ABORT; m_dl[d] = 0; end
            else begin
                e = O_DRAIN;
                m_dl[d]--;
                if (m_dl[d] == 0) m_h[d] = 1;
            end
        end else if (m_sl[d] > 0) begin e = O_STALL; m_sl[d]--; end
        else if (br) e = O_FLUSH;
        else if (lu_ref(inst, memr, irt)) begin e = O_FRZ; m_sl[d] = m_lsc[d] - 1; end
        else if (undef) begin e = O_FRZ; m_dl[d] = m_dc[d]; end
        else e = O_RUN;
    endtask

    // Called 1 time unit after a rising edge; samples mid-cycle, then advances one edge
    task automatic step();
        logic [6:0] e0, e1;
        #4;
        la = {a_pc, a_ifw, a_fl, a_ps, a_h, a_st};
        lb = {b_pc, b_ifw, b_fl, b_ps, b_h, b_st};
        if (!rst) begin
            model_cycle(0, e0);
            model_cycle(1, e1);
            chk("model_a", la, e0);
            chk("model_b", lb, e1);
        end
        @(posedge clk);
        #1;
        if (rst) model_reset();
    endtask

    task automatic idle();
        inst = 32'd0; undef = 0; memr = 0; br = 0; irt = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; step(); step(); rst = 0;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic        memr;
        logic [4:0]  rt;
        logic        br;
        logic        undef;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs [10];
    logic [5:0] ops [6] = '{6'h00, 6'h04, 6'h05, 6'h2b, 6'h08, 6'h23};

    initial begin
        vecs[0] = '{ADD_3_2_4, 1'b1, 5'd2, 1'b0, 1'b0, O_FRZ};
        vecs[1] = '{ADD_3_2_4, 1'b1, 5'd0, 1'b0, 1'b0, O_RUN};
        vecs[2] = '{ADDI_5_2,  1'b1, 5'd5, 1'b0, 1'b0, O_RUN};
        vecs[3] = '{SW_2_9,    1'b1, 5'd2, 1'b0, 1'b0, O_FRZ};
        vecs[4] = '{ADD_3_2_4, 1'b0, 5'd2, 1'b0, 1'b0, O_RUN};
        vecs[5] = '{ADD_3_2_4, 1'b1, 5'd2, 1'b1, 1'b0, O_FLUSH};
        vecs[6] = '{ADD_3_2_4, 1'b1, 5'd4, 1'b0, 1'b0, O_FRZ};
        vecs[7] = '{ADD_3_2_4, 1'b0, 5'd0, 1'b1, 1'b1, O_FLUSH};
        vecs[8] = '{BEQ_7_2,   1'b1, 5'd2, 1'b0, 1'b0, O_FRZ};
        vecs[9] = '{ADDI_5_2,  1'b1, 5'd2, 1'b0, 1'b0, O_FRZ};

        rst = 1; idle(); model_reset();
        @(posedge clk); #1;
        do_reset();
        step();
        chk("reset_outputs_a", la, O_RUN);
        chk("reset_outputs_b", lb, O_RUN);

        // Single-cycle vectors on the default instance, which never leaves RUN here
        foreach (vecs[i]) begin
            inst = vecs[i].inst; memr = vecs[i].memr; irt = vecs[i].rt;
            br = vecs[i].br; undef = vecs[i].undef;
            step();
            chk($sformatf("vec%0d", i), la, vecs[i].exp);
        end

        // Load-use with clamped 3-cycle stall on dut_b
        do_reset();
        inst = ADD_3_2_4; memr = 1; irt = 5'd2;
        step(); chk("lsc3_c0", lb, O_FRZ); chk("lsc1_c0", la, O_FRZ);
        memr = 0;
        step(); chk("lsc3_c1", lb, O_STALL); chk("lsc1_c1", la, O_RUN);
        step(); chk("lsc3_c2", lb, O_STALL);
        step(); chk("lsc3_c3", lb, O_RUN);

        // Undefined instruction: drain 3, halt on 4th edge, then inputs ignored
        do_reset();
        undef = 1;
        step(); chk("undef_run", la, O_FRZ);
        for (int k = 0; k < 3; k++) begin
            step(); chk($sformatf("drain%0d", k), la, O_DRAIN);
        end
        step(); chk("halt_4th_edge", la, O_HALT);
        for (int k = 0; k < 5; k++) begin
            inst = $urandom; undef = 1'($urandom); memr = 1; irt = 5'd2; br = 1'($urandom);
            step(); chk($sformatf("halt_hold%0d", k), la, O_HALT);
        end
        do_reset();
        step(); chk("rst_from_halt", la, O_RUN);

        // Branch aborts the drain on its second cycle
        do_reset();
        undef = 1;
        step();
        step(); chk("abort_drain1", la, O_DRAIN);
        br = 1;
        step(); chk("abort_flush", la, O_ABORT);
        idle();
        step(); chk("abort_resume", la, O_RUN);

        // Reset asserted mid-STALL
        do_reset();
        inst = ADD_3_2_4; memr = 1; irt = 5'd2;
        step();
        memr = 0;
        step(); chk("mid_stall_state", lb, O_STALL);
        rst = 1; step(); rst = 0;
        step(); chk("rst_mid_stall", lb, O_RUN);

`ifdef HAZ_PERF_CNT_EN
        do_reset();
        chk("perf_rst_stall", 32'(a_sc), 32'd0);
        chk("perf_rst_flush", 32'(a_fc), 32'd0);
        inst = ADD_3_2_4; memr = 1; irt = 5'd2;
        step();
        idle(); br = 1;
        step(); step();
        idle();
        step();
        chk("perf_stall_count", 32'(a_sc), 32'd1);
        chk("perf_flush_count", 32'(a_fc), 32'd2);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            undef = ($urandom_range(0, 15) == 0);
            br    = ($urandom_range(0, 5) == 0);
            memr  = 1'($urandom_range(0, 1));
            irt   = 5'($urandom_range(0, 3));
            inst  = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 16'($urandom)};
            step();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

- Pipeline hazard and trap sequencer for the 5-stage MIPS core.
- Sits beside the ID-stage control decoder and drives its `pipe_stall` input, plus the PC and IF/ID register enables.
- Detects load-use hazards and taken branches and sequences multi-cycle stalls and flushes.
- Drains the pipe and halts on an undefined instruction.

## Interface
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use hazard; legal range 1–3.
- `DRAIN_CYCLES`, default 3: bubbles inserted before halting on an undefined instruction; legal range 1–7.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ifid_inst` in 32: instruction in IF/ID.
- `undef_inst` in 1: `UndefInst` from the ID control decoder for `ifid_inst`.
- `idex_memr` in 1: ID/EX holds a load.
- `idex_rt` in 5: load destination register in ID/EX.
- `branch_taken` in 1: EX-stage branch resolved taken; PC mux selects the target this cycle.
- `pc_write` out 1: PC register enable.
- `ifid_write` out 1: IF/ID register enable.
- `ifid_flush` out 1: clear IF/ID to NOP on this edge.
- `pipe_stall` out 1: ID decodes a bubble (all control zero) into ID/EX.
- `halted` out 1: core halted after an undefined instruction; sticky until `rst`.
- `state` out 2: current FSM state, for debug.

## Operation
- States: RUN=0, STALL=1, DRAIN=2, HALT=3. A 3-bit counter `cnt` counts cycles in STALL and DRAIN.
- rs = `ifid_inst[25:21]`; rt = `ifid_inst[20:16]`.
- rt is a source for opcode 0 (R-type), 000100 (beq), 000101 (bne) and 101011 (sw).
- load_use = `idex_memr` AND `idex_rt`≠0 AND (`idex_rt`==rs OR (rt is a source AND `idex_rt`==rt)).
- Priority within RUN, highest first: `branch_taken`, then load_use, then `undef_inst`.
- RUN, `branch_taken`: `pc_write`=1, `ifid_flush`=1, `pipe_stall`=1; stay in RUN.
- RUN, load_use: `pc_write`=0, `ifid_write`=0, `pipe_stall`=1, `cnt`←1. If `LOAD_STALL_CYCLES`==1, stay in RUN; otherwise go to STALL.
- RUN, `undef_inst`: `pc_write`=0, `ifid_write`=0, `pipe_stall`=1, `cnt`←1, go to DRAIN.
- RUN, otherwise: `pc_write`=1, `ifid_write`=1, `pipe_stall`=0.
- STALL: same outputs as RUN load_use; load_use is not re-evaluated. `cnt`++. When `cnt`==`LOAD_STALL_CYCLES`−1 at the edge, go to RUN.
- DRAIN: same freeze outputs, so older instructions retire. `cnt`++. When `cnt`==`DRAIN_CYCLES` at the edge, go to HALT.
- DRAIN with `branch_taken` (an older branch is still in EX): abort the drain. `pc_write`=1, `ifid_flush`=1, `pipe_stall`=1, go to RUN; the undefined instruction is discarded.
- HALT: `pc_write`=0, `ifid_write`=0, `pipe_stall`=1, `halted`=1. All inputs are ignored; only `rst` exits.
- `ifid_flush` is asserted only on `branch_taken`. When `ifid_flush`=1, `ifid_write` is don't-care and driven 1.

## Timing
- All outputs are combinational from `state`, `cnt` and the current inputs. `state`, `cnt` and `halted` are registered.
- Load-use: exactly `LOAD_STALL_CYCLES` cycles with `pc_write`=0, starting the cycle the hazard is visible. The consumer leaves ID on the following edge.
- Undefined instruction: `halted` rises `DRAIN_CYCLES`+1 edges after `undef_inst` is first seen in RUN.
- Taken branch: one flush cycle, zero stall cycles.
- Reset values: `state`=RUN, `cnt`=0, `halted`=0, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `pipe_stall`=0.
- Reset has priority over every event, including a reset asserted mid-STALL, mid-DRAIN or in HALT.
- Parameters outside their legal range are clamped to the nearest legal value.

## Configuration
- `HAZ_PERF_CNT_EN` defined: adds outputs `stall_count` (out 16) and `flush_count` (out 16).
  - `stall_count` increments in every cycle with `pc_write`=0 and `halted`=0.
  - `flush_count` increments in every cycle with `ifid_flush`=1.
  - Both saturate at 16'hFFFF and clear on `rst`.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- lw $2 in ID/EX (`idex_memr`=1, `idex_rt`=2), `ifid_inst`=add $3,$2,$4 -> one cycle with `pc_write`=0, `ifid_write`=0, `pipe_stall`=1, then RUN resumes. Same stimulus with `LOAD_STALL_CYCLES`=3 -> three freeze cycles, STALL visible on `state`.
- `idex_rt`=0, or ID holds addi $5,$2,1 with `idex_rt`=5 (rt is not a source) -> no stall. sw $2,0($9) with `idex_rt`=2 -> stall.
- `branch_taken`=1 asserted together with a load_use condition -> `ifid_flush`=1, `pipe_stall`=1, `pc_write`=1, no freeze.
- `undef_inst`=1 in RUN, default parameters -> three DRAIN cycles, `halted`=1 on the 4th edge. Input activity afterwards leaves the outputs unchanged; `rst` returns all outputs to their reset values.
- `undef_inst`, then `branch_taken`=1 on the second DRAIN cycle -> flush, `state`=RUN, `halted` stays 0.
- With `HAZ_PERF_CNT_EN`: one load-use stall plus two taken branches -> `stall_count`=1, `flush_count`=2. `rst` asserted mid-STALL -> both counters 0 and `state`=RUN on the next edge.
